matmul_engine: RTL and testbench

Parameterised integer matrix-multiply engine computing C = A × B for an M×N matrix A and an N×P matrix B. It is the self-contained successor of the fixed-size multiplier datapath: it has an internal controller FSM, valid/ready streaming on input and output, configurable dimensions, and optional saturation. It sits between an upstream byte stream source and a downstream result sink.

---
 rtl/matmul_pkg.sv | 29 ++
 rtl/matmul_mac.sv | 28 ++
 rtl/matmul_engine.sv | 191 +++++++++++++++++++
 tb/tb_matmul_engine.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } mm_state_t;

  // Ceiling log2; clog2_f(1) == 0.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Bits needed to hold an index in 0..v-1, never less than one.
  function automatic int idx_width(input int v);
    return (v <= 1) ? 1 : clog2_f(v);
  endfunction

  // Exact accumulator width for N products of two dw-bit operands.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + clog2_f(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Unsigned multiply-accumulate: one DW x DW product per enabled cycle.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW = 8,
  parameter int RW = 18
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [RW-1:0] sum_o
);
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   acc_q;
  logic [RW-1:0]   acc_d;

  assign prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
  assign acc_d = (clr_i ? '0 : acc_q) + RW'(prod);

  // Accumulator: clear-and-load on the first term, then add each further term.
  always_ff @(posedge clk_i) begin
    if (en_i) acc_q <= acc_d;
  end

  assign sum_o = acc_q;
endmodule

// File: rtl/matmul_engine.sv
// Streaming C = A x B engine: load A and B row-major, compute, stream C out.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DW  = 8,
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int P   = 4,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inValid,
  output logic          inReady,
  input  logic [DW-1:0] inData,
  output logic          outValid,
  input  logic          outReady,
  output logic [DW-1:0] outData,
  output logic          outOverflow,
  output logic          overflow,
  output logic          busy,
  output logic          done
);
  localparam int RW  = acc_width(DW, N);
  localparam int LDN = (M * N > N * P) ? M * N : N * P;
  localparam int LW  = idx_width(LDN);
  localparam int IW  = idx_width(M);
  localparam int JW  = idx_width(P);
  localparam int KW  = idx_width(N + 1);
  localparam int CW  = idx_width(M * P);
  localparam int AW  = idx_width(M * N);
  localparam int BW  = idx_width(N * P);

  logic [DW-1:0] a_mem [M*N];
  logic [DW-1:0] b_mem [N*P];
  logic [RW:0]   c_mem [M*P];   // MSB is the per-element overflow tag

  mm_state_t     state_q;
  logic [LW-1:0] ld_q;
  logic [IW-1:0] ci_q;
  logic [JW-1:0] cj_q;
  logic [KW-1:0] ck_q;
  logic [CW-1:0] ce_q;
  logic [CW-1:0] oi_q;
  logic          inReady_q, outValid_q, outOvf_q, ovf_q, busy_q, done_q;
  logic [DW-1:0] outData_q;

  logic          in_xfer, out_xfer, c_wr, mac_en, mac_clr, wr_tag;
  logic [KW-1:0] k_eff;
  logic [DW-1:0] a_op, b_op;
  logic [RW-1:0] sum;
  logic [RW:0]   wr_val, c_first, c_next;
  logic [CW-1:0] oi_next;

  // Truncate, or clamp tagged elements when saturation is enabled.
  function automatic logic [DW-1:0] fmt_out(input logic [RW:0] c);
    if (SAT != 0 && c[RW]) return '1;
    return c[DW-1:0];
  endfunction

  assign in_xfer  = inValid && inReady_q;
  assign out_xfer = outValid_q && outReady;
  assign c_wr     = (state_q == COMPUTE) && (ck_q == KW'(N));
  assign mac_en   = (state_q == COMPUTE) && (ck_q != KW'(N));
  assign mac_clr  = (ck_q == '0);
  // The write cycle (k == N) has no operand; park the index at 0.
  assign k_eff    = (ck_q == KW'(N)) ? '0 : ck_q;
  assign a_op     = a_mem[AW'(int'(ci_q) * N + int'(k_eff))];
  assign b_op     = b_mem[BW'(int'(k_eff) * P + int'(cj_q))];
  assign wr_tag   = |sum[RW-1:DW];
  assign wr_val   = {wr_tag, sum};
  // A 1x1 result is written on the same edge it is first presented.
  assign c_first  = (M * P == 1) ? wr_val : c_mem[0];
  assign oi_next  = (oi_q == CW'(M * P - 1)) ? '0 : oi_q + CW'(1);
  assign c_next   = c_mem[oi_next];

  matmul_mac #(.DW(DW), .RW(RW)) u_mac (
    .clk_i (clk),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_op),
    .b_i   (b_op),
    .sum_o (sum)
  );

  // Matrix storage: capture streamed operands and finished results.
  always_ff @(posedge clk) begin
    if (in_xfer && state_q == LOAD_A) a_mem[AW'(ld_q)] <= inData;
    if (in_xfer && state_q == LOAD_B) b_mem[BW'(ld_q)] <= inData;
    if (c_wr) c_mem[ce_q] <= wr_val;
  end

  // Controller: load A, load B, compute each C element, stream C out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      ld_q        <= '0;
      ci_q        <= '0;
      cj_q        <= '0;
      ck_q        <= '0;
      ce_q        <= '0;
      oi_q        <= '0;
      inReady_q   <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outOvf_q    <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD_A: begin
          inReady_q <= 1'b1;
          if (in_xfer) begin
            if (ld_q == '0) ovf_q <= 1'b0;
            if (ld_q == LW'(M * N - 1)) begin
              ld_q    <= '0;
              state_q <= LOAD_B;
            end else begin
              ld_q <= ld_q + LW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            if (ld_q == LW'(N * P - 1)) begin
              ld_q      <= '0;
              inReady_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= COMPUTE;
            end else begin
              ld_q <= ld_q + LW'(1);
            end
          end
        end
        COMPUTE: begin
          if (ck_q == KW'(N)) begin
            ck_q <= '0;
            if (wr_tag) ovf_q <= 1'b1;
            if (ce_q == CW'(M * P - 1)) begin
              ce_q       <= '0;
              ci_q       <= '0;
              cj_q       <= '0;
              oi_q       <= '0;
              outValid_q <= 1'b1;
              outData_q  <= fmt_out(c_first);
              outOvf_q   <= c_first[RW];
              state_q    <= OUTPUT;
            end else begin
              ce_q <= ce_q + CW'(1);
              if (cj_q == JW'(P - 1)) begin
                cj_q <= '0;
                ci_q <= ci_q + IW'(1);
              end else begin
                cj_q <= cj_q + JW'(1);
              end
            end
          end else begin
            ck_q <= ck_q + KW'(1);
          end
        end
        OUTPUT: begin
          if (out_xfer) begin
            if (oi_q == CW'(M * P - 1)) begin
              oi_q       <= '0;
              outValid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              inReady_q  <= 1'b1;
              state_q    <= LOAD_A;
            end else begin
              oi_q      <= oi_next;
              outData_q <= fmt_out(c_next);
              outOvf_q  <= c_next[RW];
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign inReady     = inReady_q;
  assign outValid    = outValid_q;
  assign outData     = outData_q;
  assign outOverflow = outOvf_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench: three engine instances (2x2x2 wrap, 2x2x2 saturate,
// 1x3x2) share stimulus; sel routes handshakes to one instance at a time.
module tb_matmul_engine;
  typedef int iq_t[$];

  logic       clk, rst, inValid, outReady;
  logic [7:0] inData;
  int         sel;
  int         checks, errors;

  logic       inValid_0, inValid_1, inValid_2, outReady_0, outReady_1, outReady_2;
  logic       inReady_0, inReady_1, inReady_2, outValid_0, outValid_1, outValid_2;
  logic [7:0] outData_0, outData_1, outData_2;
  logic       outOvf_0, outOvf_1, outOvf_2, ovf_0, ovf_1, ovf_2;
  logic       busy_0, busy_1, busy_2, done_0, done_1, done_2;

  logic       inReady_m, outValid_m, outOvf_m, ovf_m, busy_m, done_m;
  logic [7:0] outData_m;

  assign inValid_0  = inValid && (sel == 0);
  assign inValid_1  = inValid && (sel == 1);
  assign inValid_2  = inValid && (sel == 2);
  assign outReady_0 = outReady && (sel == 0);
  assign outReady_1 = outReady && (sel == 1);
  assign outReady_2 = outReady && (sel == 2);

  always_comb begin
    inReady_m = inReady_0; outValid_m = outValid_0; outData_m = outData_0;
    outOvf_m = outOvf_0; ovf_m = ovf_0; busy_m = busy_0; done_m = done_0;
    if (sel == 1) begin
      inReady_m = inReady_1; outValid_m = outValid_1; outData_m = outData_1;
      outOvf_m = outOvf_1; ovf_m = ovf_1; busy_m = busy_1; done_m = done_1;
    end else if (sel == 2) begin
      inReady_m = inReady_2; outValid_m = outValid_2; outData_m = outData_2;
      outOvf_m = outOvf_2; ovf_m = ovf_2; busy_m = busy_2; done_m = done_2;
    end
  end

  matmul_engine #(.DW(8), .M(2), .N(2), .P(2), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .inValid(inValid_0), .inReady(inReady_0), .inData(inData),
    .outValid(outValid_0), .outReady(outReady_0), .outData(outData_0),
    .outOverflow(outOvf_0), .overflow(ovf_0), .busy(busy_0), .done(done_0));

  matmul_engine #(.DW(8), .M(2), .N(2), .P(2), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .inValid(inValid_1), .inReady(inReady_1), .inData(inData),
    .outValid(outValid_1), .outReady(outReady_1), .outData(outData_1),
    .outOverflow(outOvf_1), .overflow(ovf_1), .busy(busy_1), .done(done_1));

  matmul_engine #(.DW(8), .M(1), .N(3), .P(2), .SAT(0)) u_rect (
    .clk(clk), .rst(rst), .inValid(inValid_2), .inReady(inReady_2), .inData(inData),
    .outValid(outValid_2), .outReady(outReady_2), .outData(outData_2),
    .outOverflow(outOvf_2), .overflow(ovf_2), .busy(busy_2), .done(done_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream a sequence into the selected engine; gaps idles every other cycle.
  task automatic load_seq(input iq_t v, input bit gaps);
    int i, guard;
    bit xfer;
    i = 0;
    guard = 0;
    while (i < v.size() && guard < 300) begin
      if (gaps && (guard % 2 == 1)) inValid = 1'b0;
      else begin inValid = 1'b1; inData = 8'(v[i]); end
      xfer = inValid && inReady_m;
      step();
      if (xfer) i++;
      guard++;
    end
    inValid = 1'b0;
    checks++;
    if (i != v.size()) begin
      errors++;
      $display("FAIL load_timeout sent %0d required %0d", i, v.size());
    end
  endtask

  // Drain n results with outReady held high; lat counts cycles to first valid.
  task automatic collect(input int n, output iq_t got, output iq_t tags, output int lat);
    int guard;
    got = {};
    tags = {};
    lat = -1;
    guard = 0;
    outReady = 1'b1;
    while (got.size() < n && guard < 500) begin
      if (outValid_m) begin
        if (lat < 0) lat = guard;
        got.push_back(int'(outData_m));
        tags.push_back(int'(outOvf_m));
      end
      step();
      guard++;
    end
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL collect_timeout got %0d required %0d", got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({inReady_m, outValid_m, outOvf_m, ovf_m, busy_m, done_m} !== 6'b0 || outData_m !== 8'd0) begin
      errors++;
      $display("FAIL reset_values flags %b data %0d required 000000 and 0",
               {inReady_m, outValid_m, outOvf_m, ovf_m, busy_m, done_m}, outData_m);
    end
    step();
    checks++;
    if (inReady_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready got %b required 1", inReady_m);
    end
  endtask

  task automatic test_basic();
    iq_t got, tags, exp;
    int lat;
    sel = 0;
    exp = '{19, 22, 43, 50};
    load_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    checks++;
    if (busy_m !== 1'b1 || inReady_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy busy %b inReady %b required 1 0", busy_m, inReady_m);
    end
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== exp[e] || tags[e] !== 0) begin
        errors++;
        $display("FAIL basic_elem%0d got %0d tag %0d required %0d tag 0", e, got[e], tags[e], exp[e]);
      end
    end
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL basic_latency got %0d required 12", lat);
    end
    checks++;
    if (done_m !== 1'b1 || inReady_m !== 1'b1 || busy_m !== 1'b0 || ovf_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done %b inReady %b busy %b ovf %b required 1 1 0 0",
               done_m, inReady_m, busy_m, ovf_m);
    end
    step();
    checks++;
    if (done_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got %b required 0", done_m);
    end
  endtask

  task automatic test_back_to_back();
    iq_t got, tags, exp;
    int lat;
    sel = 0;
    exp = '{2, 4, 6, 8};
    load_seq('{2, 0, 0, 2, 1, 2, 3, 4}, 1'b0);
    collect(4, got, tags, lat);
    load_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== exp[e]) begin
        errors++;
        $display("FAIL b2b_first_elem%0d got %0d required %0d", e, got[e], exp[e]);
      end
    end
    exp = '{19, 22, 43, 50};
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== exp[e]) begin
        errors++;
        $display("FAIL b2b_second_elem%0d got %0d required %0d", e, got[e], exp[e]);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    iq_t got, tags;
    int lat;
    sel = 0;
    load_seq('{255, 255, 255, 255, 255, 255, 255, 255}, 1'b0);
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== 2 || tags[e] !== 1) begin
        errors++;
        $display("FAIL wrap_elem%0d got %0d tag %0d required 2 tag 1", e, got[e], tags[e]);
      end
    end
    checks++;
    if (ovf_m !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky got %b required 1", ovf_m);
    end
    step();
    step();
    checks++;
    if (ovf_m !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky_hold got %b required 1", ovf_m);
    end
    load_seq('{1}, 1'b0);
    checks++;
    if (ovf_m !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear got %b required 0", ovf_m);
    end
    load_seq('{2, 3, 4, 5, 6, 7, 8}, 1'b0);
    collect(4, got, tags, lat);
    checks++;
    if (got[3] !== 50 || tags[3] !== 0 || ovf_m !== 1'b0) begin
      errors++;
      $display("FAIL wrap_next_job got %0d tag %0d ovf %b required 50 0 0", got[3], tags[3], ovf_m);
    end
  endtask

  task automatic test_saturate();
    iq_t got, tags;
    int lat;
    sel = 1;
    load_seq('{255, 255, 255, 255, 255, 255, 255, 255}, 1'b0);
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== 255 || tags[e] !== 1) begin
        errors++;
        $display("FAIL sat_elem%0d got %0d tag %0d required 255 tag 1", e, got[e], tags[e]);
      end
    end
    checks++;
    if (ovf_m !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %b required 1", ovf_m);
    end
    load_seq('{1}, 1'b0);
    checks++;
    if (ovf_m !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %b required 0", ovf_m);
    end
    load_seq('{2, 3, 4, 5, 6, 7, 8}, 1'b0);
    collect(4, got, tags, lat);
    checks++;
    if (got[0] !== 19 || got[3] !== 50) begin
      errors++;
      $display("FAIL sat_small got %0d %0d required 19 50", got[0], got[3]);
    end
  endtask

  task automatic test_backpressure();
    iq_t exp;
    int guard, cnt;
    sel = 0;
    exp = '{19, 22, 43, 50};
    outReady = 1'b0;
    load_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    guard = 0;
    while (!outValid_m && guard < 100) begin step(); guard++; end
    cnt = 0;
    for (int e = 0; e < 4; e++) begin
      outReady = 1'b0;
      for (int s = 0; s < 5; s++) begin
        checks++;
        if (outValid_m !== 1'b1 || outData_m !== 8'(exp[e])) begin
          errors++;
          $display("FAIL bp_hold%0d_%0d valid %b data %0d required 1 %0d", e, s, outValid_m, outData_m, exp[e]);
        end
        step();
      end
      outReady = 1'b1;
      if (outValid_m) cnt++;
      step();
    end
    outReady = 1'b0;
    checks++;
    if (cnt !== 4 || done_m !== 1'b1 || outValid_m !== 1'b0) begin
      errors++;
      $display("FAIL bp_count count %0d done %b valid %b required 4 1 0", cnt, done_m, outValid_m);
    end
  endtask

  task automatic test_gaps();
    iq_t got, tags, exp;
    int lat;
    sel = 0;
    exp = '{19, 22, 43, 50};
    load_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== exp[e]) begin
        errors++;
        $display("FAIL gaps_elem%0d got %0d required %0d", e, got[e], exp[e]);
      end
    end
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL gaps_latency got %0d required 12", lat);
    end
  endtask

  task automatic test_reset_mid();
    iq_t got, tags, exp;
    int lat;
    sel = 0;
    exp = '{19, 22, 43, 50};
    load_seq('{255, 255, 255, 255, 255, 255, 255, 255}, 1'b0);
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (busy_m !== 1'b1 || ovf_m !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre busy %b ovf %b required 1 1", busy_m, ovf_m);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({inReady_m, outValid_m, outOvf_m, ovf_m, busy_m, done_m} !== 6'b0 || outData_m !== 8'd0) begin
      errors++;
      $display("FAIL midrst_values flags %b data %0d required 000000 and 0",
               {inReady_m, outValid_m, outOvf_m, ovf_m, busy_m, done_m}, outData_m);
    end
    step();
    checks++;
    if (inReady_m !== 1'b1 || outValid_m !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready inReady %b valid %b required 1 0", inReady_m, outValid_m);
    end
    load_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
    collect(4, got, tags, lat);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got[e] !== exp[e]) begin
        errors++;
        $display("FAIL midrst_elem%0d got %0d required %0d", e, got[e], exp[e]);
      end
    end
  endtask

  task automatic test_nonsquare();
    iq_t got, tags;
    int lat;
    sel = 2;
    load_seq('{1, 2, 3, 1, 0, 0, 1, 1, 1}, 1'b0);
    collect(2, got, tags, lat);
    checks++;
    if (got[0] !== 4 || got[1] !== 5) begin
      errors++;
      $display("FAIL rect_elems got %0d %0d required 4 5", got[0], got[1]);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL rect_latency got %0d required 8", lat);
    end
    checks++;
    if (done_m !== 1'b1 || inReady_m !== 1'b1) begin
      errors++;
      $display("FAIL rect_done done %b inReady %b required 1 1", done_m, inReady_m);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 0;
    rst = 1'b1;
    inValid = 1'b0;
    inData = 8'd0;
    outReady = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow_wrap();
    test_saturate();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_nonsquare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
